// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard scan-code receiver.
// The raw clock and data pins are synchronised and the clock is de-glitched.
// Each frame's start, odd parity and stop bits are checked. A frame in
// progress is abandoned when its clock stops for too long.
// Optional build macro: PS2_BREAK_DECODE_EN. When it is defined, a good F0
// prefix byte is folded into is_break on the following byte instead of
// being presented on data_reg.
module ps2_scancode_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_reg,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       is_break,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FLT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic [FW-1:0]          flt_cnt_q;
  logic                   fclk_q, fclk_d_q;
  logic                   sclk, sdat, fall;

  state_t        state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_ok_q, par_ok_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    data_reg_q, data_reg_d;
  logic          dv_q, dv_d, pe_q, pe_d, fe_q, fe_d;
`ifdef PS2_BREAK_DECODE_EN
  logic          brk_q, brk_d, bp_q, bp_d;
`endif

  assign sclk = clk_sync_q[SYNC_STAGES-1];
  assign sdat = dat_sync_q[SYNC_STAGES-1];
  assign fall = fclk_d_q & ~fclk_q;

  // Pin synchronisers; idle-high so reset loads ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Clock de-glitch: fclk follows sclk only after FILTER_LEN disagreeing samples in a row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_cnt_q <= '0;
      fclk_q    <= 1'b1;
      fclk_d_q  <= 1'b1;
    end else begin
      fclk_d_q <= fclk_q;
      if (sclk == fclk_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_MAX) begin
        flt_cnt_q <= '0;
        fclk_q    <= sclk;
      end else begin
        flt_cnt_q <= flt_cnt_q + FW'(1);
      end
    end
  end

  // FSM, shift register, timeout and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      par_ok_q   <= 1'b0;
      to_q       <= '0;
      data_reg_q <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
`ifdef PS2_BREAK_DECODE_EN
      brk_q      <= 1'b0;
      bp_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      par_ok_q   <= par_ok_d;
      to_q       <= to_d;
      data_reg_q <= data_reg_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
`ifdef PS2_BREAK_DECODE_EN
      brk_q      <= brk_d;
      bp_q       <= bp_d;
`endif
    end
  end

  // Next state: timeout has priority; otherwise advance one bit per filtered falling edge.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    par_ok_d   = par_ok_q;
    data_reg_d = data_reg_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    fe_d       = 1'b0;
`ifdef PS2_BREAK_DECODE_EN
    brk_d      = brk_q;
    bp_d       = bp_q;
`endif
    if (state_q == IDLE || fall) to_d = '0;
    else                         to_d = to_q + TW'(1);

    if (state_q != IDLE && to_q == TO_MAX) begin
      state_d = IDLE;
      fe_d    = 1'b1;
`ifdef PS2_BREAK_DECODE_EN
      bp_d    = 1'b0;
`endif
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!sdat) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shreg_d  = {sdat, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_ok_d = ^{shreg_q, sdat};
          state_d  = STOP;
        end
        default: begin
          state_d = IDLE;
          if (!sdat) begin
            // A bad stop bit masks any parity failure in the same frame.
            fe_d = 1'b1;
`ifdef PS2_BREAK_DECODE_EN
            bp_d = 1'b0;
`endif
          end else if (!par_ok_q) begin
            pe_d = 1'b1;
`ifdef PS2_BREAK_DECODE_EN
            bp_d = 1'b0;
`endif
          end else begin
`ifdef PS2_BREAK_DECODE_EN
            if (shreg_q == 8'hF0) begin
              bp_d = 1'b1;
            end else begin
              data_reg_d = shreg_q;
              dv_d       = 1'b1;
              brk_d      = bp_q;
              bp_d       = 1'b0;
            end
`else
            data_reg_d = shreg_q;
            dv_d       = 1'b1;
`endif
          end
        end
      endcase
    end
  end

  assign data_reg   = data_reg_q;
  assign data_valid = dv_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign busy       = (state_q != IDLE);
`ifdef PS2_BREAK_DECODE_EN
  assign is_break   = brk_q;
`else
  assign is_break   = 1'b0;
`endif

endmodule
